// File: rtl/sort4_seq_ctrl.sv
// Serial 4-key sorter: loads four keys, runs the 5-step odd-even merge network on one
// shared comparator, then drains keys ascending. Define SORT4_SWAPCNT_EN to add swap_cnt.
module sort4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef SORT4_SWAPCNT_EN
  ,
  output logic [2:0]       swap_cnt
`endif
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] r [4];
  logic [1:0]       wr_idx;
  logic [1:0]       rd_idx;
  logic [2:0]       step;
  logic [1:0]       cmp_a;
  logic [1:0]       cmp_b;
  logic             do_swap;
  logic             accept;
  logic             emit;

  // Compare-exchange pair {a, b} for each step of the odd-even merge network.
  function automatic logic [3:0] pair_sel(input logic [2:0] s);
    case (s)
      3'd1:    return {2'd2, 2'd3};
      3'd2:    return {2'd0, 2'd2};
      3'd3:    return {2'd1, 2'd3};
      3'd4:    return {2'd1, 2'd2};
      default: return {2'd0, 2'd1};
    endcase
  endfunction

  assign {cmp_a, cmp_b} = pair_sel(step);
  assign do_swap = (state == SORT) && (r[cmp_a] > r[cmp_b]);
  assign accept  = in_valid && in_ready;
  assign emit    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && (wr_idx == 2'd3)) state_nxt = SORT;
      SORT:    if (step == 3'd4)               state_nxt = DRAIN;
      DRAIN:   if (emit && out_last)           state_nxt = LOAD;
      default:                                 state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == LOAD);
    out_valid = (state == DRAIN);
    out_data  = out_valid ? r[rd_idx] : '0;
    out_last  = out_valid && (rd_idx == 2'd3);
    busy      = (state != LOAD) || (wr_idx != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      step     <= 3'd0;
`ifdef SORT4_SWAPCNT_EN
      swap_cnt <= 3'd0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            r[wr_idx] <= in_data;
            wr_idx    <= wr_idx + 2'd1;
            if (wr_idx == 2'd3) begin
              step     <= 3'd0;
`ifdef SORT4_SWAPCNT_EN
              swap_cnt <= 3'd0;
`endif
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            r[cmp_a] <= r[cmp_b];
            r[cmp_b] <= r[cmp_a];
`ifdef SORT4_SWAPCNT_EN
            swap_cnt <= swap_cnt + 3'd1;
`endif
          end
          step <= step + 3'd1;
          if (step == 3'd4) rd_idx <= 2'd0;
        end
        DRAIN: begin
          if (emit) rd_idx <= rd_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Directed bench for sort4_seq_ctrl: hand-computed sort results, latency,
// backpressure, ignored input during sort/drain and mid-sort reset.
module tb_sort4_seq_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
`ifdef SORT4_SWAPCNT_EN
  logic [2:0]       swap_cnt;
`endif

  int          n_cmp;
  int          n_err;
  bit          noisy;
  logic [31:0] rnd;

  sort4_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef SORT4_SWAPCNT_EN
    ,
    .swap_cnt  (swap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic noise();
    if (noisy) begin
      rnd     = $urandom;
      in_valid = 1'b1;
      in_data = rnd[WIDTH-1:0];
    end
  endtask

  task automatic push_key(input logic [WIDTH-1:0] k, input bit keep);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = k;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic load4(input logic [WIDTH-1:0] k0, input logic [WIDTH-1:0] k1,
                       input logic [WIDTH-1:0] k2, input logic [WIDTH-1:0] k3, input bit keep);
    push_key(k0, 1'b0);
    push_key(k1, 1'b0);
    push_key(k2, 1'b0);
    push_key(k3, keep);
  endtask

  // Starts right after the 4th accept edge; returns at the first negedge with out_valid.
  task automatic wait_valid(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      noise();
      if (out_valid || n >= 40) break;
      check("ir_sort", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic drain(input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                       input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3, input bit stall);
    logic [WIDTH-1:0] ev [4];
    int g;
    ev = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      g = 0;
      while (!out_valid && g < 40) begin
        @(negedge clk);
        g++;
        noise();
      end
      if (stall) begin
        for (int s = 0; s < 3; s++) begin
          check("hold_data", 32'(out_data), 32'(ev[i]));
          check("hold_last", 32'(out_last), 32'(i == 3));
          check("ir_stall", 32'(in_ready), 32'd0);
          @(negedge clk);
          noise();
        end
      end
      check("out_data", 32'(out_data), 32'(ev[i]));
      check("out_last", 32'(out_last), 32'(i == 3));
      check("ir_drain", 32'(in_ready), 32'd0);
      check("busy_drain", 32'(busy), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = !stall;
      if (i == 3) begin
        if (noisy) in_valid = 1'b0;
        check("ir_after_last", 32'(in_ready), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
        check("ov_after_last", 32'(out_valid), 32'd0);
      end else begin
        @(negedge clk);
        noise();
      end
    end
  endtask

  task automatic run_block(input logic [WIDTH-1:0] k0, input logic [WIDTH-1:0] k1,
                           input logic [WIDTH-1:0] k2, input logic [WIDTH-1:0] k3,
                           input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                           input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3,
                           input bit stall, input bit noise_en, input int swaps);
    int n;
    out_ready = !stall;
    noisy     = 1'b0;
    load4(k0, k1, k2, k3, noise_en);
    noisy = noise_en;
    wait_valid(n);
    check("latency", 32'(n), 32'd6);
    drain(e0, e1, e2, e3, stall);
    noisy = 1'b0;
`ifdef SORT4_SWAPCNT_EN
    check("swap_cnt", 32'(swap_cnt), 32'(swaps));
`else
    if (swaps < 0) check("swaps_arg", 32'(swaps), 32'd0);
`endif
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    noisy     = 1'b0;
    rnd       = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_gated", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SORT4_SWAPCNT_EN
    check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
`endif

    run_block(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 5);
    run_block(4'd15, 4'd10, 4'd5, 4'd0, 4'd0, 4'd5, 4'd10, 4'd15, 1'b0, 1'b0, 4);
    run_block(4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 0);
    run_block(4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 1'b0, 0);
    run_block(4'd12, 4'd3, 4'd8, 4'd1, 4'd1, 4'd3, 4'd8, 4'd12, 1'b1, 1'b0, 5);
    run_block(4'd6, 4'd2, 4'd14, 4'd2, 4'd2, 4'd2, 4'd6, 4'd14, 1'b0, 1'b1, 3);

    // Reset lands on the edge that would execute sort step 2.
    out_ready = 1'b1;
    load4(4'd1, 4'd0, 4'd1, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
`ifdef SORT4_SWAPCNT_EN
    check("pre_rst_swap_cnt", 32'(swap_cnt), 32'd2);
`endif
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SORT4_SWAPCNT_EN
    check("mid_rst_swap_cnt", 32'(swap_cnt), 32'd0);
`endif
    run_block(4'd9, 4'd8, 4'd7, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 1'b0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
